// File: rtl/sm4_pkg.sv
// Shared SM4 S-box constants: forward table, inverse table derived from it,
// and the lane count of the 32-bit datapath.
package sm4_pkg;

  localparam int unsigned LANES = 4;

  localparam logic [7:0] SBOX [256] = '{
    8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7, 8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05,
    8'h2B, 8'h67, 8'h9A, 8'h76, 8'h2A, 8'hBE, 8'h04, 8'hC3, 8'hAA, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9C, 8'h42, 8'h50, 8'hF4, 8'h91, 8'hEF, 8'h98, 8'h7A, 8'h33, 8'h54, 8'h0B, 8'h43, 8'hED, 8'hCF, 8'hAC, 8'h62,
    8'hE4, 8'hB3, 8'h1C, 8'hA9, 8'hC9, 8'h08, 8'hE8, 8'h95, 8'h80, 8'hDF, 8'h94, 8'hFA, 8'h75, 8'h8F, 8'h3F, 8'hA6,
    8'h47, 8'h07, 8'hA7, 8'hFC, 8'hF3, 8'h73, 8'h17, 8'hBA, 8'h83, 8'h59, 8'h3C, 8'h19, 8'hE6, 8'h85, 8'h4F, 8'hA8,
    8'h68, 8'h6B, 8'h81, 8'hB2, 8'h71, 8'h64, 8'hDA, 8'h8B, 8'hF8, 8'hEB, 8'h0F, 8'h4B, 8'h70, 8'h56, 8'h9D, 8'h35,
    8'h1E, 8'h24, 8'h0E, 8'h5E, 8'h63, 8'h58, 8'hD1, 8'hA2, 8'h25, 8'h22, 8'h7C, 8'h3B, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hD4, 8'h00, 8'h46, 8'h57, 8'h9F, 8'hD3, 8'h27, 8'h52, 8'h4C, 8'h36, 8'h02, 8'hE7, 8'hA0, 8'hC4, 8'hC8, 8'h9E,
    8'hEA, 8'hBF, 8'h8A, 8'hD2, 8'h40, 8'hC7, 8'h38, 8'hB5, 8'hA3, 8'hF7, 8'hF2, 8'hCE, 8'hF9, 8'h61, 8'h15, 8'hA1,
    8'hE0, 8'hAE, 8'h5D, 8'hA4, 8'h9B, 8'h34, 8'h1A, 8'h55, 8'hAD, 8'h93, 8'h32, 8'h30, 8'hF5, 8'h8C, 8'hB1, 8'hE3,
    8'h1D, 8'hF6, 8'hE2, 8'h2E, 8'h82, 8'h66, 8'hCA, 8'h60, 8'hC0, 8'h29, 8'h23, 8'hAB, 8'h0D, 8'h53, 8'h4E, 8'h6F,
    8'hD5, 8'hDB, 8'h37, 8'h45, 8'hDE, 8'hFD, 8'h8E, 8'h2F, 8'h03, 8'hFF, 8'h6A, 8'h72, 8'h6D, 8'h6C, 8'h5B, 8'h51,
    8'h8D, 8'h1B, 8'hAF, 8'h92, 8'hBB, 8'hDD, 8'hBC, 8'h7F, 8'h11, 8'hD9, 8'h5C, 8'h41, 8'h1F, 8'h10, 8'h5A, 8'hD8,
    8'h0A, 8'hC1, 8'h31, 8'h88, 8'hA5, 8'hCD, 8'h7B, 8'hBD, 8'h2D, 8'h74, 8'hD0, 8'h12, 8'hB8, 8'hE5, 8'hB4, 8'hB0,
    8'h89, 8'h69, 8'h97, 8'h4A, 8'h0C, 8'h96, 8'h77, 8'h7E, 8'h65, 8'hB9, 8'hF1, 8'h09, 8'hC5, 8'h6E, 8'hC6, 8'h84,
    8'h18, 8'hF0, 8'h7D, 8'hEC, 8'h3A, 8'hDC, 8'h4D, 8'h20, 8'h79, 8'hEE, 8'h5F, 8'h3E, 8'hD7, 8'hCB, 8'h39, 8'h48
  };

  // Inverse table is elaborated from the forward table so the two can never disagree.
  function automatic logic [255:0][7:0] build_inv_sbox();
    logic [255:0][7:0] t;
    t = '0;
    for (int unsigned i = 0; i < 256; i++) begin
      t[SBOX[i[7:0]]] = i[7:0];
    end
    return t;
  endfunction

  localparam logic [255:0][7:0] INV_SBOX = build_inv_sbox();

endpackage

// File: rtl/sm4_inv_sbox_32b_if.sv
// Valid/ready bundle for the 32-bit SM4 inverse S-box: input word stream,
// output word stream and busy flag.
interface sm4_inv_sbox_32b_if;
  logic [31:0] x;
  logic        x_valid;
  logic        x_ready;
  logic [31:0] y;
  logic        y_valid;
  logic        y_ready;
  logic        busy;

  modport master (output x, x_valid, y_ready, input x_ready, y, y_valid, busy);
  modport slave  (input x, x_valid, y_ready, output x_ready, y, y_valid, busy);
endinterface

// File: rtl/sm4_inv_sbox_8b.sv
// One byte lane of the SM4 inverse S-box: table lookup captured in a register
// that only loads when CE_i is high.
module sm4_inv_sbox_8b (
  input  logic       CLK_i,
  input  logic       CE_i,
  input  logic [7:0] X_i,
  output logic [7:0] Y_o
);
  import sm4_pkg::*;

  logic [7:0] y_d;
  logic [7:0] y_q;

  always_comb begin
    y_d = INV_SBOX[X_i];
  end

  always_ff @(posedge CLK_i) begin
    if (CE_i) begin
      y_q <= y_d;
    end
  end

  assign Y_o = y_q;
endmodule

// File: rtl/sm4_inv_sbox_32b.sv
// 32-bit SM4 inverse S-box: four lookup lanes in stage 1, optional output
// register in stage 2, valid/ready flow control with one word per cycle.
module sm4_inv_sbox_32b #(
  parameter int unsigned OUT_REG = 1
) (
  input  logic        CLK_i,
  input  logic        RST_i,
  input  logic [31:0] X_i,
  input  logic        X_VALID_i,
  output logic        X_READY_o,
  output logic [31:0] Y_o,
  output logic        Y_VALID_o,
  input  logic        Y_READY_i,
  output logic        BUSY_o
);
  import sm4_pkg::*;

  logic                 v1_d;
  logic                 v1_q;
  logic                 adv1;
  logic [8*LANES-1:0]   lut_y;
  logic                 y_valid_int;
  logic [31:0]          y_int;
  logic                 busy_int;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sm4_inv_sbox_8b u_lane (
      .CLK_i (CLK_i),
      .CE_i  (adv1),
      .X_i   (X_i[8*k +: 8]),
      .Y_o   (lut_y[8*k +: 8])
    );
  end

  always_comb begin
    v1_d = v1_q;
    if (adv1) begin
      v1_d = X_VALID_i;
    end
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      v1_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic        adv2;
    logic        v2_d;
    logic        v2_q;
    logic [31:0] y2_d;
    logic [31:0] y2_q;

    always_comb begin
      adv2 = !v2_q || Y_READY_i;
      v2_d = v2_q;
      y2_d = y2_q;
      if (adv2) begin
        v2_d = v1_q;
        y2_d = lut_y;
      end
    end

    always_ff @(posedge CLK_i) begin
      if (RST_i) begin
        v2_q <= 1'b0;
        y2_q <= '0;
      end else begin
        v2_q <= v2_d;
        y2_q <= y2_d;
      end
    end

    assign adv1        = !v1_q || adv2;
    assign y_valid_int = v2_q;
    assign y_int       = y2_q;
    assign busy_int    = v1_q || v2_q;
  end else begin : g_nooreg
    assign adv1        = !v1_q || Y_READY_i;
    assign y_valid_int = v1_q;
    assign y_int       = lut_y;
    assign busy_int    = v1_q;
  end

  // Outputs are forced idle while reset is held, before the valid bits clear.
  assign X_READY_o = !RST_i && adv1;
  assign Y_VALID_o = !RST_i && y_valid_int;
  assign Y_o       = RST_i ? '0 : y_int;
  assign BUSY_o    = !RST_i && busy_int;
endmodule

// File: tb/tb_sm4_inv_sbox_32b.sv
// Directed and randomized checks of sm4_inv_sbox_32b with and without the
// output register; expected words come from the pre-substitution originals.
module tb_sm4_inv_sbox_32b;
  import sm4_pkg::*;

  logic clk = 1'b0;
  logic rst;

  sm4_inv_sbox_32b_if bus();

  logic [31:0] x0;
  logic        xv0;
  logic        xr0;
  logic [31:0] y0;
  logic        yv0;
  logic        yr0;
  logic        busy0;

  always #5 clk = ~clk;

  sm4_inv_sbox_32b #(.OUT_REG(1)) u_dut (
    .CLK_i     (clk),
    .RST_i     (rst),
    .X_i       (bus.x),
    .X_VALID_i (bus.x_valid),
    .X_READY_o (bus.x_ready),
    .Y_o       (bus.y),
    .Y_VALID_o (bus.y_valid),
    .Y_READY_i (bus.y_ready),
    .BUSY_o    (bus.busy)
  );

  sm4_inv_sbox_32b #(.OUT_REG(0)) u_dut0 (
    .CLK_i     (clk),
    .RST_i     (rst),
    .X_i       (x0),
    .X_VALID_i (xv0),
    .X_READY_o (xr0),
    .Y_o       (y0),
    .Y_VALID_o (yv0),
    .Y_READY_i (yr0),
    .BUSY_o    (busy0)
  );

  int          checks = 0;
  int          errors = 0;
  int          emit_cnt = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_word;
  bit          prev_stall = 0;
  logic [31:0] prev_y;

  function automatic logic [31:0] fwd(input logic [31:0] w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = SBOX[w[8*k +: 8]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Mid-cycle sample of the OUT_REG=1 instance: stall hold, scoreboard, accept.
  task automatic sample(output bit acc);
    logic [31:0] e;
    #4;
    acc = 0;
    if (rst) begin
      exp_q.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {31'b0, bus.y_valid}, 32'd1);
        chk("hold_data", bus.y, prev_y);
      end
      if (bus.y_valid && bus.y_ready) begin
        emit_cnt++;
        if (exp_q.size() == 0) chk("spurious_out", {31'b0, bus.y_valid}, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("out_word", bus.y, e);
        end
      end
      if (bus.x_valid && bus.x_ready) begin
        exp_q.push_back(exp_word);
        acc = 1;
      end
      prev_stall = bus.y_valid && !bus.y_ready;
      prev_y     = bus.y;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    int          stall_cnt;
    int          n;
    int          e0;
    int          idx;
    int          n_acc;
    bit          pend;
    logic [31:0] bx [4];
    logic [31:0] be [4];
    logic [31:0] orig;

    rst = 1; bus.x = 32'hD690E948; bus.x_valid = 1; bus.y_ready = 1; exp_word = '0;
    x0 = 32'h48484848; xv0 = 1; yr0 = 1;

    // reset state
    repeat (2) begin
      sample(acc);
      chk("rst_y_valid", {31'b0, bus.y_valid}, 32'd0);
      chk("rst_busy", {31'b0, bus.busy}, 32'd0);
      chk("rst_x_ready", {31'b0, bus.x_ready}, 32'd0);
      chk("rst_y", bus.y, 32'h0);
      chk("rst_y_valid0", {31'b0, yv0}, 32'd0);
      chk("rst_x_ready0", {31'b0, xr0}, 32'd0);
      tick();
    end
    rst = 0; bus.x_valid = 0; xv0 = 0;
    sample(acc);
    chk("x_ready_after_rst", {31'b0, bus.x_ready}, 32'd1);
    chk("x_ready0_after_rst", {31'b0, xr0}, 32'd1);
    tick();

    // single word, two-cycle latency
    bus.x = 32'hD690E948; exp_word = 32'h000102FF; bus.x_valid = 1;
    sample(acc);
    chk("single_accept", {31'b0, acc}, 32'd1);
    tick();
    bus.x_valid = 0;
    sample(acc);
    chk("single_lat1_valid", {31'b0, bus.y_valid}, 32'd0);
    chk("single_lat1_busy", {31'b0, bus.busy}, 32'd1);
    tick();
    sample(acc);
    chk("single_lat2_valid", {31'b0, bus.y_valid}, 32'd1);
    chk("single_data", bus.y, 32'h000102FF);
    tick();
    sample(acc);
    chk("single_idle_busy", {31'b0, bus.busy}, 32'd0);
    tick();

    // 256-word stream at full throughput
    emit_cnt = 0; stall_cnt = 0; bus.x_valid = 1;
    for (int b = 0; b < 256; b++) begin
      bus.x = {4{SBOX[b[7:0]]}};
      exp_word = {4{b[7:0]}};
      do begin
        sample(acc);
        if (!acc) stall_cnt++;
        tick();
      end while (!acc && stall_cnt < 1000);
    end
    bus.x_valid = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      sample(acc);
      tick();
      n++;
    end
    chk("stream_no_stall", stall_cnt, 0);
    chk("stream_emit_cnt", emit_cnt, 256);
    chk("stream_drain_cycles", n, 2);

    // backpressure with three words offered
    bx[0] = 32'hD690E948; be[0] = 32'h000102FF;
    for (int i = 1; i < 4; i++) begin
      be[i] = $urandom;
      bx[i] = fwd(be[i]);
    end
    bus.y_ready = 0; idx = 0; e0 = emit_cnt;
    for (int c = 0; c < 5; c++) begin
      bus.x_valid = (idx < 3);
      bus.x = bx[idx]; exp_word = be[idx];
      sample(acc);
      if (acc) idx++;
      if (c >= 2) begin
        chk("bp_x_ready", {31'b0, bus.x_ready}, 32'd0);
        chk("bp_y_valid", {31'b0, bus.y_valid}, 32'd1);
        chk("bp_y", bus.y, 32'h000102FF);
      end
      tick();
    end
    chk("bp_accepted_when_full", idx, 2);
    bus.y_ready = 1;
    for (int c = 0; c < 20 && (idx < 3 || exp_q.size() != 0); c++) begin
      bus.x_valid = (idx < 3);
      bus.x = bx[idx]; exp_word = be[idx];
      sample(acc);
      if (acc) idx++;
      tick();
    end
    bus.x_valid = 0;
    chk("bp_all_accepted", idx, 3);
    chk("bp_emitted", emit_cnt - e0, 3);

    // reset with two words in flight
    bus.y_ready = 0; bus.x_valid = 1;
    for (int i = 0; i < 2; i++) begin
      orig = $urandom; bus.x = fwd(orig); exp_word = orig;
      sample(acc);
      chk("rst_mid_accept", {31'b0, acc}, 32'd1);
      tick();
    end
    bus.x_valid = 0; rst = 1;
    sample(acc);
    chk("rst_mid_gate_valid", {31'b0, bus.y_valid}, 32'd0);
    tick();
    rst = 0;
    sample(acc);
    chk("rst_mid_y_valid", {31'b0, bus.y_valid}, 32'd0);
    chk("rst_mid_busy", {31'b0, bus.busy}, 32'd0);
    tick();
    bus.y_ready = 1; e0 = emit_cnt;
    repeat (5) begin
      sample(acc);
      tick();
    end
    chk("rst_mid_no_out", emit_cnt - e0, 0);

    // random round trip with random stalls
    n_acc = 0; pend = 0; e0 = emit_cnt;
    for (int c = 0; c < 40000 && n_acc < 10000; c++) begin
      if (!pend) begin
        orig = $urandom; bus.x = fwd(orig); exp_word = orig;
        pend = ($urandom_range(0, 3) != 0);
      end
      bus.x_valid = pend;
      bus.y_ready = ($urandom_range(0, 3) != 0);
      sample(acc);
      if (acc) begin
        n_acc++;
        pend = 0;
      end
      tick();
    end
    bus.x_valid = 0; bus.y_ready = 1;
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
      sample(acc);
      tick();
    end
    chk("rt_accepted", n_acc, 10000);
    chk("rt_emitted", emit_cnt - e0, 10000);
    chk("rt_drained", exp_q.size(), 0);

    // OUT_REG=0 instance: one-cycle latency and stall behaviour
    x0 = 32'h48484848; xv0 = 1; yr0 = 1;
    sample(acc);
    chk("o0_accept", {31'b0, xr0}, 32'd1);
    tick();
    xv0 = 0;
    sample(acc);
    chk("o0_valid", {31'b0, yv0}, 32'd1);
    chk("o0_data", y0, 32'hFFFFFFFF);
    tick();
    sample(acc);
    chk("o0_empty_valid", {31'b0, yv0}, 32'd0);
    chk("o0_empty_busy", {31'b0, busy0}, 32'd0);
    tick();
    yr0 = 0; xv0 = 1; x0 = fwd(32'h01020304);
    sample(acc);
    chk("o0_stall_accept", {31'b0, xr0}, 32'd1);
    tick();
    x0 = fwd(32'hA5C3_5A3C);
    repeat (2) begin
      sample(acc);
      chk("o0_stall_valid", {31'b0, yv0}, 32'd1);
      chk("o0_stall_data", y0, 32'h01020304);
      chk("o0_stall_x_ready", {31'b0, xr0}, 32'd0);
      tick();
    end
    yr0 = 1;
    sample(acc);
    chk("o0_release_x_ready", {31'b0, xr0}, 32'd1);
    tick();
    xv0 = 0;
    sample(acc);
    chk("o0_second_valid", {31'b0, yv0}, 32'd1);
    chk("o0_second_data", y0, 32'hA5C35A3C);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
